// File: rtl/mul_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_16bit
//  Purpose  : Sequential shift-add multiplier, product = A*B + odd.
//             Inverse of the 16-bit by 8-bit restoring divider: given a
//             quotient (A), divisor (B) and remainder (odd) it rebuilds the
//             dividend. One multiplier bit is consumed per clock.
//  Ports    : clk     - rising-edge clock
//             rst     - asynchronous active-high reset
//             start   - operation request, sampled only while idle
//             A       - 16-bit unsigned multiplicand (quotient)
//             B       - 8-bit unsigned multiplier (divisor)
//             odd     - 16-bit unsigned addend (remainder)
//             busy    - computation in progress
//             done    - one-cycle pulse, product valid from this cycle on
//             product - 24-bit result, held until the next done
//             ovf     - product[23:16] non-zero, updated with product
//  Revision : 1.0 - initial release
// ============================================================================
module mul_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  input  logic [15:0] odd,
  output logic        busy,
  output logic        done,
  output logic [23:0] product,
  output logic        ovf
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST_BIT = 3'd7;

  state_t      state_q;
  logic [23:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [23:0] acc_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [23:0] product_q;
  logic        ovf_q;

  logic [23:0] partial_d;
  logic [23:0] acc_d;

  // Partial product for the current multiplier bit. The accumulator is
  // 24 bits wide; the largest result (0xFFFF00) fits, so no wrap occurs.
  always_comb begin
    partial_d = 24'h0;
    if (mplier_q[cnt_q]) begin
      partial_d = mcand_q << cnt_q;
    end
    acc_d = acc_q + partial_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 24'h0;
      mplier_q  <= 8'h0;
      acc_q     <= 24'h0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 24'h0;
      ovf_q     <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the final CALC edge re-raises it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Operands are captured so input changes during CALC are ignored.
            mcand_q  <= {8'h00, A};
            mplier_q <= B;
            acc_q    <= {8'h00, odd};
            cnt_q    <= 3'd0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == c_LAST_BIT) begin
            product_q <= acc_d;
            ovf_q     <= |acc_d[23:16];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_16bit
//  Purpose  : Self-checking bench for mul_16bit. Expected {ovf, product}
//             pairs are queued when an operation is issued and popped when
//             done is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] odd;
  logic        busy;
  logic        done;
  logic [23:0] product;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [24:0] sb[$];   // {ovf, product}

  int overlap_cnt = 0;
  int double_cnt  = 0;
  logic done_prev = 1'b0;

  mul_16bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .odd    (odd),
    .busy   (busy),
    .done   (done),
    .product(product),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol watchers: busy/done overlap and back-to-back done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) overlap_cnt++;
      if (done && done_prev) double_cnt++;
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b,
                                        input logic [15:0] o);
    logic [23:0] p;
    p = 24'(a) * 24'(b) + 24'(o);
    return {(p[23:16] != 8'h00), p};
  endfunction

  // Issues one operation and waits (bounded) for done; no checking here.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] o,
                        input bit imm, output int lat, output int bcnt, output bit seen);
    if (!imm) @(negedge clk);
    A = a; B = b; odd = o; start = 1'b1;
    sb.push_back(model(a, b, o));
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      lat++;
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; odd = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf, product} !== 27'h0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b product=%h, want all 0",
               busy, done, ovf, product);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt; bit seen; logic [24:0] exp;
    run_op(16'd100, 8'd7, 16'd3, 1'b0, lat, bcnt, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL basic_done: got timeout, want done"); end
    exp = sb.pop_front();
    checks++;
    if (product !== exp[23:0] || product !== 24'h0002BF) begin
      failures++; $display("FAIL basic_product: got %h, want %h", product, 24'h0002BF);
    end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b, want 0", ovf); end
    checks++;
    if (lat != 8) begin failures++; $display("FAIL basic_latency: got %0d, want 8", lat); end
    checks++;
    if (bcnt != 8) begin failures++; $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || product !== 24'h0002BF) begin
      failures++;
      $display("FAIL basic_hold: got done=%b product=%h, want 0 0002bf", done, product);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit seen; logic [24:0] exp;
    run_op(16'hFFFF, 8'hFF, 16'hFFFF, 1'b0, lat, bcnt, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || product !== exp[23:0] || product !== 24'hFFFF00) begin
      failures++; $display("FAIL max_product: got %h seen=%b, want fff f00 -> %h", product, seen, 24'hFFFF00);
    end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL max_ovf: got %b, want 1", ovf); end
    // Second start issued in the done cycle itself.
    run_op(16'd0, 8'd0, 16'd5, 1'b1, lat, bcnt, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || lat != 8) begin
      failures++; $display("FAIL b2b_latency: got %0d seen=%b, want 8", lat, seen);
    end
    checks++;
    if (product !== exp[23:0] || product !== 24'd5 || ovf !== 1'b0) begin
      failures++; $display("FAIL b2b_product: got %h ovf=%b, want 000005 0", product, ovf);
    end
  endtask

  task automatic test_roundtrip();
    int lat, bcnt; bit seen; logic [24:0] exp;
    logic [15:0] a, o; logic [7:0] b;
    for (int n = 0; n < 16; n++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      o = 16'($urandom_range(0, int'(b) - 1));
      if (n == 0) a = 16'd255;
      run_op(a, b, o, 1'b0, lat, bcnt, seen);
      exp = sb.pop_front();
      checks++;
      if (!seen || product !== exp[23:0] || ovf !== exp[24]) begin
        failures++;
        $display("FAIL rt_product[%0d]: got %h ovf=%b, want %h ovf=%b", n, product, ovf, exp[23:0], exp[24]);
      end
      checks++;
      if ((product / 24'(b)) !== 24'(a) || (product % 24'(b)) !== 24'(o)) begin
        failures++;
        $display("FAIL rt_divide[%0d]: got q=%0d r=%0d, want q=%0d r=%0d", n,
                 product / 24'(b), product % 24'(b), a, o);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones; logic [24:0] exp;
    @(negedge clk);
    A = 16'd10; B = 8'd3; odd = 16'd0; start = 1'b1;
    sb.push_back(model(16'd10, 8'd3, 16'd0));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 16'd1; B = 8'd1; start = 1'b1;   // sampled at E3, must be ignored
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          exp = sb.pop_front();
          checks++;
          if (product !== exp[23:0] || product !== 24'd30) begin
            failures++; $display("FAIL busy_start_product: got %h, want 00001e", product);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL busy_start_dones: got %0d, want 1", dones); end
  endtask

  task automatic test_async_reset();
    int lat, bcnt; bit seen; logic [24:0] exp;
    @(negedge clk);
    A = 16'd300; B = 8'd9; odd = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;    // after E0
    repeat (4) @(negedge clk);       // after E4
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf, product} !== 27'h0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b ovf=%b product=%h, want all 0",
               busy, done, ovf, product);
    end
    @(negedge clk); rst = 1'b0;
    run_op(16'd2, 8'd2, 16'd1, 1'b0, lat, bcnt, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || product !== exp[23:0] || product !== 24'd5) begin
      failures++; $display("FAIL post_reset_product: got %h seen=%b, want 000005", product, seen);
    end
  endtask

  task automatic test_operand_change();
    bit seen; logic [24:0] exp;
    @(negedge clk);
    A = 16'd123; B = 8'd200; odd = 16'd77; start = 1'b1;
    sb.push_back(model(16'd123, 8'd200, 16'd77));
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin seen = 1'b1; break; end
      A = 16'($urandom); B = 8'($urandom); odd = 16'($urandom);
      @(negedge clk);
    end
    exp = sb.pop_front();
    checks++;
    if (!seen || product !== exp[23:0] || product !== 24'd24677) begin
      failures++; $display("FAIL operand_change: got %h seen=%b, want %h", product, seen, 24'd24677);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (overlap_cnt != 0) begin failures++; $display("FAIL busy_done_overlap: got %0d, want 0", overlap_cnt); end
    checks++;
    if (double_cnt != 0) begin failures++; $display("FAIL double_done: got %0d, want 0", double_cnt); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left: got %0d, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_roundtrip();
    test_start_while_busy();
    test_async_reset();
    test_operand_change();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
